// File: rtl/latent_sample_collector_pkg.sv
// rtl/latent_sample_collector_pkg.sv - shared types and helpers for the latent sample collector
package latent_sample_collector_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FLUSH   = 2'd1,
      DRAIN   = 2'd2
   } lsc_state_e;

   // Latency of the current lambda reparameterization sampler build.
   localparam int DEFAULT_LAMBDA_LATENCY = 10;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/latent_sample_collector_tag.sv
// rtl/latent_sample_collector_tag.sv - valid_tag_delay: 1-bit valid tag line matched to a fixed layer latency
module valid_tag_delay #(
   parameter int DEPTH = 10
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic tag_i,
   output logic tag_o
);

   logic [DEPTH-1:0] tag_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tag_q <= '0;
      end else begin
         tag_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/latent_sample_collector.sv
// rtl/latent_sample_collector.sv - captures tagged sampler outputs into a frame and streams it to the decoder
module latent_sample_collector
   import latent_sample_collector_pkg::*;
#(
   parameter int BITSIZE        = 20,
   parameter int NUM_LATENT     = 8,
   parameter int LAMBDA_LATENCY = DEFAULT_LAMBDA_LATENCY
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                issue_valid,
   output logic                                issue_ready,
   input  logic [BITSIZE-1:0]                  lambda_in,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [BITSIZE-1:0]                  out_data,
   output logic [idx_width(NUM_LATENT)-1:0]    out_index,
   output logic                                out_last,
   output logic                                drop_err
);

   localparam int IW = idx_width(NUM_LATENT);
   localparam int CW = $clog2(NUM_LATENT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(NUM_LATENT);
   localparam logic [CW-1:0] LAST_CNT = CW'(NUM_LATENT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LATENT - 1);

   lsc_state_e                state_q, state_d;
   logic [CW-1:0]             issue_cnt_q, issue_cnt_d;
   logic [IW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [IW-1:0]             out_index_q, out_index_d;
   logic [BITSIZE-1:0]        out_data_q, out_data_d;
   logic                      out_valid_q, out_valid_d;
   logic                      out_last_q, out_last_d;
   logic                      drop_err_q, drop_err_d;
   logic                      ready_en_q;
   logic [BITSIZE-1:0]        frame_q [NUM_LATENT];
   logic                      accept, capture;
   logic [IW-1:0]             next_idx;

   assign issue_ready = ready_en_q && (state_q == COLLECT) && (issue_cnt_q < FULL_CNT);
   assign accept      = issue_valid && issue_ready;
   assign next_idx    = out_index_q + IW'(1);

   valid_tag_delay #(.DEPTH(LAMBDA_LATENCY)) u_tag (
      .clk_i   (clk),
      .rst_n_i (reset_n),
      .tag_i   (accept),
      .tag_o   (capture)
   );

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
      drop_err_d  = drop_err_q || (issue_valid && !issue_ready);

      if (accept) issue_cnt_d = issue_cnt_q + CW'(1);
      if (capture && (wr_ptr_q != LAST_IDX)) wr_ptr_d = wr_ptr_q + IW'(1);

      case (state_q)
         COLLECT: begin
            if (accept && (issue_cnt_q == LAST_CNT)) state_d = FLUSH;
         end
         FLUSH: begin
            // The last capture writes slot N-1 on this edge, so slot 0 is safe to preload.
            if (capture && (wr_ptr_q == LAST_IDX)) begin
               state_d     = DRAIN;
               out_valid_d = 1'b1;
               out_data_d  = frame_q[0];
               out_index_d = '0;
               out_last_d  = 1'b0;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (out_last_q) begin
                  state_d     = COLLECT;
                  issue_cnt_d = '0;
                  wr_ptr_d    = '0;
                  out_valid_d = 1'b0;
                  out_data_d  = '0;
                  out_index_d = '0;
                  out_last_d  = 1'b0;
               end else begin
                  out_index_d = next_idx;
                  out_data_d  = frame_q[next_idx];
                  out_last_d  = (next_idx == LAST_IDX);
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= COLLECT;
         issue_cnt_q <= '0;
         wr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
         drop_err_q  <= 1'b0;
         ready_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
         drop_err_q  <= drop_err_d;
         ready_en_q  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) frame_q[wr_ptr_q] <= lambda_in;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;
   assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_latent_sample_collector.sv
// tb/tb_latent_sample_collector.sv - randomized frame-level bench for latent_sample_collector
module tb_latent_sample_collector;

   localparam int BITS = 20;
   localparam int N    = 4;
   localparam int L    = 3;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            issue_valid = 1'b0;
   logic            issue_ready;
   logic [BITS-1:0] lambda_in = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [BITS-1:0] out_data;
   logic [1:0]      out_index;
   logic            out_last;
   logic            drop_err;

   always #5 clk = ~clk;

   latent_sample_collector #(
      .BITSIZE        (BITS),
      .NUM_LATENT     (N),
      .LAMBDA_LATENCY (L)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .lambda_in   (lambda_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_index   (out_index),
      .out_last    (out_last),
      .drop_err    (drop_err)
   );

   int              n_tests = 0;
   int              n_fail  = 0;
   int              cyc = 0;
   int              acc_cnt = 0;
   int              acc_cyc[$];
   int              phase = 0;
   int              exp_rd = 0;
   int              frames_done = 0;
   bit              exp_drop = 1'b0;
   logic [BITS-1:0] hist[int];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      acc_cnt = 0;
      acc_cyc.delete();
      phase   = 0;
      exp_rd  = 0;
      exp_drop = 1'b0;
   endtask

   // phase: 0 accepting issues, 1 waiting for in-flight samples, 2 streaming the frame
   task automatic step(input int p_issue, input int p_ready, input bit coop);
      bit exp_ready, exp_valid;
      int src;
      @(negedge clk);
      if (phase == 1 && cyc == acc_cyc[N-1] + L + 1) phase = 2;
      exp_ready = (phase == 0) && (acc_cnt < N);
      exp_valid = (phase == 2);
      check("issue_ready", 32'(issue_ready), 32'(exp_ready));
      check("out_valid",   32'(out_valid),   32'(exp_valid));
      check("drop_err",    32'(drop_err),    32'(exp_drop));
      if (exp_valid) begin
         src = acc_cyc[exp_rd] + L;
         check("out_data",  32'(out_data),  32'(hist[src]));
         check("out_index", 32'(out_index), 32'(exp_rd));
         check("out_last",  32'(out_last),  32'(exp_rd == N - 1));
      end else begin
         check("out_last_idle", 32'(out_last), 32'd0);
      end

      issue_valid = (int'($urandom_range(99)) < p_issue) && (!coop || exp_ready);
      out_ready   = int'($urandom_range(99)) < p_ready;
      lambda_in   = BITS'($urandom);
      hist[cyc]   = lambda_in;

      if (issue_valid) begin
         if (exp_ready) begin
            acc_cyc.push_back(cyc);
            acc_cnt++;
            if (acc_cnt == N) phase = 1;
         end else begin
            exp_drop = 1'b1;
         end
      end
      if (exp_valid && out_ready) begin
         if (exp_rd == N - 1) begin
            phase = 0;
            acc_cnt = 0;
            acc_cyc.delete();
            exp_rd = 0;
            frames_done++;
         end else begin
            exp_rd++;
         end
      end
      cyc++;
   endtask

   task automatic run_frames(input int nf, input int p_issue, input int p_ready, input bit coop);
      int target, budget;
      target = frames_done + nf;
      budget = 0;
      while (frames_done < target && budget < 400 * nf) begin
         step(p_issue, p_ready, coop);
         budget++;
      end
      check("frame_timeout", 32'(frames_done), 32'(target));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_issue_ready"}, 32'(issue_ready), 32'd0);
      check({tag, "_out_valid"},   32'(out_valid),   32'd0);
      check({tag, "_out_data"},    32'(out_data),    32'd0);
      check({tag, "_out_index"},   32'(out_index),   32'd0);
      check({tag, "_out_last"},    32'(out_last),    32'd0);
      check({tag, "_drop_err"},    32'(drop_err),    32'd0);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2 reset_n = 1'b0;
      issue_valid = 1'b0;
      out_ready   = 1'b0;
      #1 check_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int budget;
      #3 check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();

      run_frames(1, 100, 100, 1'b1);
      run_frames(2, 40, 100, 1'b1);
      run_frames(2, 100, 25, 1'b1);

      budget = 0;
      while (phase != 2 && budget < 200) begin
         step(100, 0, 1'b1);
         budget++;
      end
      check("drain_reach", 32'(phase), 32'd2);
      repeat (5) step(0, 0, 1'b1);
      run_frames(1, 0, 50, 1'b1);

      run_frames(1, 100, 100, 1'b0);
      check("overflow_flag", 32'(exp_drop), 32'd1);
      run_frames(2, 70, 60, 1'b0);

      budget = 0;
      while (phase != 1 && budget < 200) begin
         step(100, 100, 1'b1);
         budget++;
      end
      repeat (2) step(0, 100, 1'b1);
      check("flush_reach", 32'(phase), 32'd1);
      async_reset();

      run_frames(3, 80, 80, 1'b1);
      run_frames(2, 60, 70, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
